sysid_checker: RTL and testbench

Avalon-MM master that sits directly downstream of the system ID slave. It reads the ID word (address 0) and the build timestamp (address 1), and compares both against compile-time expected values. It reports pass/fail status to the HPS-visible status logic and the board LEDs. Each read transaction has a watchdog timeout with bounded retry, so a hung fabric is reported rather than silently stalling boot.

---
 rtl/sysid_checker_if.sv | 13 +
 rtl/sysid_checker.sv | 140 ++++++++++++++
 tb/tb_sysid_checker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_if.sv
// Avalon-MM read link between sysid_checker (master) and the system ID slave.
interface sysid_checker_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (output avm_address, avm_read,
                   input  avm_waitrequest, avm_readdata, avm_readdatavalid);
   modport slave  (input  avm_address, avm_read,
                   output avm_waitrequest, avm_readdata, avm_readdatavalid);
endinterface

// File: rtl/sysid_checker.sv
// Reads sysid ID/timestamp words, compares against expected values, with per-read watchdog and retry.
// SYSID_CHK_TS_CHECK_EN enables the timestamp read; undefined means the check ends after the ID word.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID = 32'hACD51302,
`ifdef SYSID_CHK_TS_CHECK_EN
   parameter logic [31:0] EXPECTED_TS = 32'h537969B7,
`endif
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned MAX_RETRY   = 3,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   sysid_checker_if.master        avm,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic                   pass,
   output logic                   id_ok,
   output logic                   ts_ok,
   output logic [31:0]            id_value,
   output logic [31:0]            ts_value,
   output logic [1:0]             retry_cnt
);
   typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE, FAIL} state_t;

   localparam logic [7:0] WD_LAST   = 8'(TIMEOUT_CYC - 1);
   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

   state_t     state, nxt;
   logic [7:0] wd_cnt;
   logic       seen_q, first_q;
   logic       accept, capture, timeout, clr, in_busy, nxt_rd, nxt_busy;

   always_comb begin
      nxt      = state;
      accept   = avm.avm_read & ~avm.avm_waitrequest;
      capture  = 1'b0;
      timeout  = 1'b0;
      clr      = 1'b0;
      in_busy  = (state == RD_ID) || (state == WT_ID) || (state == RD_TS) || (state == WT_TS);
      case (state)
         IDLE:  if ((AUTO_START && first_q) || start) nxt = RD_ID;
         RD_ID: if (accept) nxt = WT_ID;
         WT_ID: if (avm.avm_readdatavalid) begin
            capture = 1'b1;
`ifdef SYSID_CHK_TS_CHECK_EN
            nxt     = RD_TS;
`else
            nxt     = DONE;
`endif
         end
`ifdef SYSID_CHK_TS_CHECK_EN
         RD_TS: if (accept) nxt = WT_TS;
         WT_TS: if (avm.avm_readdatavalid) begin
            capture = 1'b1;
            nxt     = DONE;
         end
`endif
         DONE, FAIL: if (start) begin
            clr = 1'b1;
            nxt = RD_ID;
         end
         default: nxt = IDLE;
      endcase
      // Watchdog spans the whole RD+WT transaction; a retry always restarts from the ID word.
      if (in_busy && !capture && (wd_cnt == WD_LAST)) begin
         timeout = 1'b1;
         nxt     = (retry_cnt < RETRY_MAX) ? RD_ID : FAIL;
      end
      nxt_rd   = (nxt == RD_ID) || (nxt == RD_TS);
      nxt_busy = nxt_rd || (nxt == WT_ID) || (nxt == WT_TS);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state           <= IDLE;
         seen_q          <= 1'b0;
         first_q         <= 1'b0;
         wd_cnt          <= '0;
         avm.avm_read    <= 1'b0;
         avm.avm_address <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         fail            <= 1'b0;
         pass            <= 1'b0;
         id_ok           <= 1'b0;
         id_value        <= '0;
         retry_cnt       <= '0;
`ifdef SYSID_CHK_TS_CHECK_EN
         ts_ok           <= 1'b0;
         ts_value        <= '0;
`endif
      end else begin
         state   <= nxt;
         seen_q  <= 1'b1;
         first_q <= ~seen_q;
         if (nxt_rd && ((nxt != state) || timeout)) wd_cnt <= '0;
         else if (in_busy)                            wd_cnt <= wd_cnt + 8'd1;
         // Read drops for one cycle on timeout, even when retrying straight back into RD_ID.
         avm.avm_read    <= nxt_rd & ~timeout;
         avm.avm_address <= (nxt == RD_TS);
         busy            <= nxt_busy;
         done            <= (nxt == DONE);
         fail            <= (nxt == FAIL);
         if (clr) begin
            id_value  <= '0;
            id_ok     <= 1'b0;
            pass      <= 1'b0;
            retry_cnt <= '0;
`ifdef SYSID_CHK_TS_CHECK_EN
            ts_value  <= '0;
            ts_ok     <= 1'b0;
`endif
         end
         if (capture && (state == WT_ID)) begin
            id_value <= avm.avm_readdata;
            id_ok    <= (avm.avm_readdata == EXPECTED_ID);
`ifndef SYSID_CHK_TS_CHECK_EN
            pass     <= (avm.avm_readdata == EXPECTED_ID);
`endif
         end
`ifdef SYSID_CHK_TS_CHECK_EN
         if (capture && (state == WT_TS)) begin
            ts_value <= avm.avm_readdata;
            ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
            pass     <= id_ok && (avm.avm_readdata == EXPECTED_TS);
         end
`endif
         if (timeout && (retry_cnt < RETRY_MAX)) retry_cnt <= retry_cnt + 2'd1;
      end
   end

`ifndef SYSID_CHK_TS_CHECK_EN
   assign ts_value = '0;
   assign ts_ok    = 1'b1;
`endif

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: nominal, stall, mismatch, hung slave, reset and start handling.
module tb_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'hACD51302;
   localparam logic [31:0] EXP_TS = 32'h537969B7;
`ifdef SYSID_CHK_TS_CHECK_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif
   localparam int DONE_CYC = TS_EN ? 5 : 3;
   localparam int RST_R    = TS_EN ? 4 : 2;

   logic        clock, reset_n, start;
   logic        busy, done, fail, pass, id_ok, ts_ok;
   logic [31:0] id_value, ts_value;
   logic [1:0]  retry_cnt;

   logic        hang, force_rdv, rdv_q;
   logic [31:0] rdata_q, id_word, ts_word;
   int          ws_id, ws_seen, acc0, acc1;
   int          n_pass, n_total;

   sysid_checker_if bus();

   sysid_checker #(.TIMEOUT_CYC(10)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .avm(bus),
      .busy(busy), .done(done), .fail(fail), .pass(pass),
      .id_ok(id_ok), .ts_ok(ts_ok), .id_value(id_value), .ts_value(ts_value),
      .retry_cnt(retry_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave model: optional ID-read stall, fixed latency 1, or accept-and-never-answer when hung.
   assign bus.avm_waitrequest   = bus.avm_read && !bus.avm_address && (ws_seen < ws_id);
   assign bus.avm_readdatavalid = rdv_q | force_rdv;
   assign bus.avm_readdata      = force_rdv ? EXP_ID : rdata_q;

   initial begin
      rdv_q = 1'b0; rdata_q = '0; ws_seen = 0; acc0 = 0; acc1 = 0;
   end

   always @(posedge clock) begin
      rdv_q <= 1'b0;
      if (!bus.avm_read) ws_seen <= 0;
      else if (bus.avm_waitrequest) ws_seen <= ws_seen + 1;
      else begin
         if (bus.avm_address) acc1 <= acc1 + 1;
         else                 acc0 <= acc0 + 1;
         if (!hang) begin
            rdv_q   <= 1'b1;
            rdata_q <= bus.avm_address ? ts_word : id_word;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic rerun();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_end(input int limit);
      for (int i = 0; i < limit && !(done || fail); i++) step(1);
   endtask

   int a0, a1;

   initial begin
      n_pass = 0; n_total = 0;
      reset_n = 1'b0; start = 1'b0; hang = 1'b0; force_rdv = 1'b0; ws_id = 0;
      id_word = EXP_ID; ts_word = EXP_TS;
      step(2);
      chk("rst_read", 32'(bus.avm_read), 32'(0));
      chk("rst_addr", 32'(bus.avm_address), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_fail", 32'(fail), 32'(0));
      chk("rst_pass", 32'(pass), 32'(0));
      chk("rst_id_value", id_value, 32'h0);
      chk("rst_retry", 32'(retry_cnt), 32'(0));
      chk("rst_ts_ok", 32'(ts_ok), TS_EN ? 32'(0) : 32'(1));

      // Nominal auto-start after reset release
      reset_n = 1'b1;
      step(1);
      chk("c0_read", 32'(bus.avm_read), 32'(0));
      step(1);
      chk("c1_read", 32'(bus.avm_read), 32'(1));
      chk("c1_addr", 32'(bus.avm_address), 32'(0));
      chk("c1_busy", 32'(busy), 32'(1));
      if (TS_EN) begin
         step(2);
         chk("c3_read", 32'(bus.avm_read), 32'(1));
         chk("c3_addr", 32'(bus.avm_address), 32'(1));
         step(1);
      end else step(1);
      chk("pre_done", 32'(done), 32'(0));
      step(1);
      chk("nom_done", 32'(done), 32'(1));
      chk("nom_pass", 32'(pass), 32'(1));
      chk("nom_id_value", id_value, EXP_ID);
      chk("nom_ts_value", ts_value, TS_EN ? EXP_TS : 32'h0);
      chk("nom_id_ok", 32'(id_ok), 32'(1));
      chk("nom_ts_ok", 32'(ts_ok), 32'(1));
      chk("nom_retry", 32'(retry_cnt), 32'(0));
      chk("nom_busy", 32'(busy), 32'(0));
      chk("nom_ts_reads", 32'(acc1), TS_EN ? 32'(1) : 32'(0));

      // Start in DONE reruns; start while busy is ignored
      a0 = acc0;
      rerun();
      chk("rerun_done_clr", 32'(done), 32'(0));
      chk("rerun_id_clr", id_value, 32'h0);
      chk("rerun_busy", 32'(busy), 32'(1));
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(DONE_CYC - 3);
      chk("rerun_done", 32'(done), 32'(1));
      chk("rerun_pass", 32'(pass), 32'(1));
      step(2);
      chk("busy_start_ign", 32'(done), 32'(1));
      chk("rerun_id_reads", 32'(acc0 - a0), 32'(1));

      // Waitrequest stall of 3 cycles on the ID read
      ws_id = 3;
      rerun();
      for (int r = 1; r <= 4; r++) begin
         chk($sformatf("ws_read_r%0d", r), 32'(bus.avm_read), 32'(1));
         chk($sformatf("ws_addr_r%0d", r), 32'(bus.avm_address), 32'(0));
         step(1);
      end
      chk("ws_read_drop", 32'(bus.avm_read), 32'(0));
      step(DONE_CYC - 3);
      chk("ws_pre_done", 32'(done), 32'(0));
      step(1);
      chk("ws_done", 32'(done), 32'(1));
      chk("ws_pass", 32'(pass), 32'(1));
      ws_id = 0;

      // ID mismatch does not abort the check
      id_word = 32'h12345678;
      rerun();
      wait_end(40);
      chk("idmm_done", 32'(done), 32'(1));
      chk("idmm_id_ok", 32'(id_ok), 32'(0));
      chk("idmm_ts_ok", 32'(ts_ok), 32'(1));
      chk("idmm_pass", 32'(pass), 32'(0));
      chk("idmm_id_value", id_value, 32'h12345678);
      chk("idmm_ts_value", ts_value, TS_EN ? EXP_TS : 32'h0);
      id_word = EXP_ID;

      if (TS_EN) begin
         ts_word = 32'h0;
         rerun();
         wait_end(40);
         chk("tsmm_done", 32'(done), 32'(1));
         chk("tsmm_id_ok", 32'(id_ok), 32'(1));
         chk("tsmm_ts_ok", 32'(ts_ok), 32'(0));
         chk("tsmm_pass", 32'(pass), 32'(0));
         chk("tsmm_fail", 32'(fail), 32'(0));
         ts_word = EXP_TS;
      end

      // Hung slave: 4 attempts then FAIL; late data afterwards is ignored
      hang = 1'b1;
      a0 = acc0; a1 = acc1;
      rerun();
      wait_end(200);
      chk("hang_fail", 32'(fail), 32'(1));
      chk("hang_done", 32'(done), 32'(0));
      chk("hang_retry", 32'(retry_cnt), 32'(3));
      chk("hang_busy", 32'(busy), 32'(0));
      chk("hang_attempts", 32'(acc0 - a0), 32'(4));
      chk("hang_ts_reads", 32'(acc1 - a1), 32'(0));
      force_rdv = 1'b1;
      step(1);
      force_rdv = 1'b0;
      step(2);
      chk("late_fail", 32'(fail), 32'(1));
      chk("late_done", 32'(done), 32'(0));
      chk("late_id_value", id_value, 32'h0);
      chk("late_id_ok", 32'(id_ok), 32'(0));
      hang = 1'b0;

      // Recovery from FAIL clears retry state
      rerun();
      chk("rec_retry_clr", 32'(retry_cnt), 32'(0));
      chk("rec_fail_clr", 32'(fail), 32'(0));
      wait_end(40);
      chk("rec_pass", 32'(pass), 32'(1));

      // Reset mid-transaction, then auto-restart
      rerun();
      step(RST_R - 1);
      reset_n = 1'b0;
      step(1);
      chk("mid_rst_read", 32'(bus.avm_read), 32'(0));
      chk("mid_rst_addr", 32'(bus.avm_address), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_done", 32'(done), 32'(0));
      chk("mid_rst_pass", 32'(pass), 32'(0));
      chk("mid_rst_id_value", id_value, 32'h0);
      chk("mid_rst_ts_value", ts_value, 32'h0);
      chk("mid_rst_id_ok", 32'(id_ok), 32'(0));
      reset_n = 1'b1;
      step(1);
      step(DONE_CYC);
      chk("post_rst_done", 32'(done), 32'(1));
      chk("post_rst_pass", 32'(pass), 32'(1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
